// File: rtl/sn_result_serializer_if.sv
// Bus bundle for sn_result_serializer.
// Purpose: carries the result strobe/data and overrun clear into the serializer,
//          and the serial line plus status/readback signals out of it.
// Signals:
//   result_valid  one-cycle strobe qualifying result_data
//   result_data   WIDTH-bit result to transmit
//   clr_overrun   synchronous clear of the sticky overrun flag
//   ser_out       serial line (idles high)
//   ser_frame     high for every cycle of a frame, start through stop
//   busy          same as ser_frame
//   pend_full     one-deep pending buffer is occupied
//   overrun       sticky: a result was dropped
//   last_result   value of the most recently started frame
// Modports: master = result producer, slave = serializer.
interface sn_result_serializer_if #(
    parameter int WIDTH = 10
);
    logic             result_valid;
    logic [WIDTH-1:0] result_data;
    logic             clr_overrun;
    logic             ser_out;
    logic             ser_frame;
    logic             busy;
    logic             pend_full;
    logic             overrun;
    logic [WIDTH-1:0] last_result;

    modport master (
        output result_valid, result_data, clr_overrun,
        input  ser_out, ser_frame, busy, pend_full, overrun, last_result
    );

    modport slave (
        input  result_valid, result_data, clr_overrun,
        output ser_out, ser_frame, busy, pend_full, overrun, last_result
    );
endinterface

// File: rtl/sn_result_serializer.sv
// sn_result_serializer
// Purpose: output stage for the stochastic multiplier. Takes WIDTH-bit results
//          on a one-cycle strobe, buffers one pending result, and sends each as
//          an async-serial frame: start(0), data LSB first, even parity, stop(1).
//          Each bit is held CLKS_PER_BIT cycles. Dropped results set a sticky
//          overrun flag; last_result reads back the value of the latest frame.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sn_result_serializer_if.slave (strobe/data/clear in; line/status out)
// All outputs come straight from flops.
module sn_result_serializer #(
    parameter int WIDTH        = 10,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sn_result_serializer_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] last_result_q, last_result_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_frame_q, ser_frame_d;

    logic             final_stop;
    logic             launch;
    logic [WIDTH-1:0] launch_val;

    assign final_stop = (state_q == ST_STOP) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        last_result_d = last_result_q;
        // Clear first so a drop on the same edge below re-sets it (set wins).
        overrun_d     = overrun_q & ~bus.clr_overrun;
        launch        = 1'b0;
        launch_val    = pend_q;

        // Bit timing: each non-idle state lasts one full bit period.
        if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (state_q)
                    ST_START: begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                    ST_DATA: begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_PARITY;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            shift_d = shift_q >> 1;
                        end
                    end
                    ST_PARITY: state_d = ST_STOP;
                    ST_STOP:   state_d = ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A pending result launches on the last stop cycle so frames run
        // back to back. It also launches from IDLE, which only happens when a
        // strobe landed on a final stop cycle with the buffer empty.
        if (pend_full_q && ((state_q == ST_IDLE) || final_stop)) begin
            launch      = 1'b1;
            launch_val  = pend_q;
            pend_full_d = 1'b0;
            if (bus.result_valid) begin
                pend_d      = bus.result_data;
                pend_full_d = 1'b1;
            end
        end else if (bus.result_valid) begin
            if (state_q == ST_IDLE) begin
                launch     = 1'b1;
                launch_val = bus.result_data;
            end else if (!pend_full_q) begin
                pend_d      = bus.result_data;
                pend_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (launch) begin
            state_d       = ST_START;
            cnt_d         = '0;
            idx_d         = '0;
            shift_d       = launch_val;
            parity_d      = ^launch_val;
            last_result_d = launch_val;
        end

        // Line level is decoded from the next state so ser_out is a flop.
        case (state_d)
            ST_START:  ser_out_d = 1'b0;
            ST_DATA:   ser_out_d = shift_d[0];
            ST_PARITY: ser_out_d = parity_d;
            default:   ser_out_d = 1'b1;
        endcase
        ser_frame_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            overrun_q     <= 1'b0;
            last_result_q <= '0;
            ser_out_q     <= 1'b1;
            ser_frame_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            overrun_q     <= overrun_d;
            last_result_q <= last_result_d;
            ser_out_q     <= ser_out_d;
            ser_frame_q   <= ser_frame_d;
        end
    end

    assign bus.ser_out     = ser_out_q;
    assign bus.ser_frame   = ser_frame_q;
    assign bus.busy        = ser_frame_q;
    assign bus.pend_full   = pend_full_q;
    assign bus.overrun     = overrun_q;
    assign bus.last_result = last_result_q;
endmodule
